// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the IF/ID pipeline register: FSM encoding, NOP and default widths,
// plus the packed entry layout held by each pipe slot.
package fetch_decode_pkg;

    localparam int unsigned IW_DEF = 16;
    localparam int unsigned AW_DEF = 32;
    localparam logic [15:0] NOP_DEF = 16'h0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    // Layout at the default widths; the top rebuilds the same layout at its own widths.
    typedef struct packed {
        logic              valid;
        logic [IW_DEF-1:0] instruction;
        logic [IW_DEF-1:0] immediate;
        logic [AW_DEF-1:0] nextPc;
        logic [AW_DEF-1:0] samePc;
    } entry_t;

endpackage

// File: rtl/pipe_slot.sv
// One loadable/clearable pipeline entry. The MSB is the valid bit; clearing drops only valid,
// so the payload (and with it the PCs) keeps its last value.
module pipe_slot #(
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [Width-1:0] dIn,
    output logic [Width-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clear) begin
            q[Width-1] <= 1'b0;
        end else if (load) begin
            q <= dIn;
        end
    end

endmodule

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer (main + skid) and flush-to-bubble.
// Optional FETCH_DECODE_STATS_EN adds saturating stallCount/bubbleCount outputs.
module fetch_decode_reg
    import fetch_decode_pkg::*;
#(
    parameter int unsigned IW  = IW_DEF,
    parameter int unsigned AW  = AW_DEF,
    parameter logic [IW-1:0] NOP = IW'(NOP_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] inInstruction,
    input  logic [IW-1:0] inImmediate,
    input  logic [AW-1:0] inNextPc,
    input  logic [AW-1:0] inSamePc,
    input  logic          inValid,
    input  logic          decodeStall,
    input  logic          flush,
    output logic          fetchStall,
    output logic [IW-1:0] outInstruction,
    output logic [IW-1:0] outImmediate,
    output logic [AW-1:0] outNextPc,
    output logic [AW-1:0] outSamePc,
`ifdef FETCH_DECODE_STATS_EN
    output logic          outValid,
    output logic [15:0]   stallCount,
    output logic [15:0]   bubbleCount
`else
    output logic          outValid
`endif
);

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] instruction;
        logic [IW-1:0] immediate;
        logic [AW-1:0] nextPc;
        logic [AW-1:0] samePc;
    } slot_t;

    localparam int unsigned SlotW = $bits(slot_t);

    state_t state, stateNext;
    slot_t  inEntry, mainD, mainQ, skidQ;
    logic   mainLoad, mainClear, skidLoad, skidClear, mainFromSkid;

    always_comb begin
        inEntry.valid       = 1'b1;
        inEntry.instruction = inInstruction;
        inEntry.immediate   = inImmediate;
        inEntry.nextPc      = inNextPc;
        inEntry.samePc      = inSamePc;
    end

    always_comb begin
        stateNext    = state;
        mainLoad     = 1'b0;
        mainClear    = 1'b0;
        skidLoad     = 1'b0;
        skidClear    = 1'b0;
        mainFromSkid = 1'b0;
        if (flush) begin
            mainClear = 1'b1;
            skidClear = 1'b1;
            stateNext = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (inValid) begin
                        mainLoad  = 1'b1;
                        stateNext = FULL;
                    end
                end
                FULL: begin
                    if (!decodeStall && inValid) begin
                        mainLoad = 1'b1;
                    end else if (!decodeStall) begin
                        mainClear = 1'b1;
                        stateNext = EMPTY;
                    end else if (inValid) begin
                        skidLoad  = 1'b1;
                        stateNext = SKID;
                    end
                end
                SKID: begin
                    // Fetch is stalled here, so the input is ignored.
                    if (!decodeStall) begin
                        mainLoad     = 1'b1;
                        mainFromSkid = 1'b1;
                        skidClear    = 1'b1;
                        stateNext    = FULL;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
        mainD = mainFromSkid ? skidQ : inEntry;
    end

    // fetchStall mirrors skid occupancy one cycle after the capture edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            fetchStall <= 1'b0;
        end else begin
            state      <= stateNext;
            fetchStall <= (stateNext == SKID);
        end
    end

    pipe_slot #(.Width(SlotW)) mainSlot (
        .clk   (clk),
        .rst   (rst),
        .load  (mainLoad),
        .clear (mainClear),
        .dIn   (mainD),
        .q     (mainQ)
    );

    pipe_slot #(.Width(SlotW)) skidSlot (
        .clk   (clk),
        .rst   (rst),
        .load  (skidLoad),
        .clear (skidClear),
        .dIn   (inEntry),
        .q     (skidQ)
    );

    assign outValid       = mainQ.valid;
    assign outInstruction = mainQ.valid ? mainQ.instruction : NOP;
    assign outImmediate   = mainQ.valid ? mainQ.immediate : '0;
    assign outNextPc      = mainQ.nextPc;
    assign outSamePc      = mainQ.samePc;

`ifdef FETCH_DECODE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCount  <= 16'h0000;
            bubbleCount <= 16'h0000;
        end else begin
            if (decodeStall && mainQ.valid && stallCount != 16'hFFFF) begin
                stallCount <= stallCount + 16'h0001;
            end
            if (!mainQ.valid && bubbleCount != 16'hFFFF) begin
                bubbleCount <= bubbleCount + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_decode_reg.md
Name: fetch_decode_reg

Overview:
- IF/ID pipeline register between the Fetch stage and the Decode stage.
- Captures Fetch's final instruction, immediate, nextPc and samePc, and presents them to Decode with a valid bit.
- A 2-entry skid buffer absorbs the one-cycle latency of Fetch's stall input. Flush on jump inserts a bubble (NOP).
- Drives the Fetch stage's stall input.

Parameters:
- IW, 16, instruction/immediate width
- AW, 32, PC width
- NOP, 16'h0000, encoding driven on outInstruction when the output slot is invalid

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- inInstruction  in  IW  final instruction from Fetch
- inImmediate  in  IW  immediate from Fetch
- inNextPc  in  AW  PC+1 from Fetch
- inSamePc  in  AW  PC of the fetched instruction
- inValid  in  1  Fetch presents a real instruction this cycle
- decodeStall  in  1  hazard unit holds Decode; output slot must not advance
- flush  in  1  jump/branch taken; discard everything held and incoming
- fetchStall  out  1  to Fetch stall; high means Fetch must hold and inValid is ignored
- outInstruction  out  IW  instruction to Decode
- outImmediate  out  IW  immediate to Decode
- outNextPc  out  AW  nextPc to Decode
- outSamePc  out  AW  samePc to Decode
- outValid  out  1  output slot holds a real instruction

Behaviour:
- Reset (rst=0, async):
  - state=EMPTY; main and skid slots invalid.
  - outInstruction=NOP, outImmediate=0, outNextPc=0, outSamePc=0, outValid=0, fetchStall=0.
- Storage: main slot drives the outputs directly (registered, no combinational path from inputs to outputs). One skid slot sits behind it.
- fetchStall = skid valid. It is registered, so it asserts the cycle after capture into skid.
- Latency: 1 cycle from inValid to outValid when not stalled.
- FSM states and transitions (evaluated when flush=0):
  - EMPTY (main invalid):
    - inValid=1 -> load main, go to FULL.
    - Otherwise stay in EMPTY.
  - FULL (main valid, skid empty):
    - decodeStall=0 and inValid=1 -> replace main with input, stay in FULL.
    - decodeStall=0 and inValid=0 -> main invalid, go to EMPTY.
    - decodeStall=1 and inValid=1 -> load skid, go to SKID.
    - decodeStall=1 and inValid=0 -> hold.
  - SKID (both valid; fetchStall=1; inputs ignored):
    - decodeStall=0 -> main<=skid, skid invalid, go to FULL.
    - decodeStall=1 -> hold.
- Flush has highest priority after reset:
  - Next edge: main and skid both invalidated, state=EMPTY, fetchStall=0.
  - Same-cycle input is discarded regardless of inValid.
  - Flush beats decodeStall when both are asserted.
- Invalid output slot:
  - outInstruction=NOP, outImmediate=0.
  - outNextPc/outSamePc hold their last values; Decode must not use them when outValid=0.
- Immediate pairing: instruction and immediate always move together as one entry, never split across slots.
- A stall held for many cycles loses no entries and duplicates none. Exactly the entries Fetch presented with fetchStall=0 and inValid=1 reach Decode, in order.
- Reset mid-operation: immediate return to reset values, both slots dropped.

Optional Feature:
- Macro: FETCH_DECODE_STATS_EN
- Defined:
  - Adds output ports stallCount[15:0] and bubbleCount[15:0], both reset to 0.
  - stallCount increments each cycle decodeStall=1 while outValid=1.
  - bubbleCount increments each cycle outValid=0 after reset.
  - Both counters saturate at 16'hFFFF, and flush does not clear them.
- Undefined: ports and counters absent; function otherwise identical.

Decomposition:
- Shared package fetch_decode_pkg:
  - state encoding EMPTY=2'd0, FULL=2'd1, SKID=2'd2
  - NOP constant
  - IW/AW defaults
  - packed entry layout {valid, instruction, immediate, nextPc, samePc}
- One sub-module, pipe_slot: a single loadable/clearable entry register with async active-low reset. It is instantiated twice (main, skid).

Test Plan:
- Reset then inValid=1 with inInstruction=16'h1234, inImmediate=16'h00AB, inSamePc=5, inNextPc=6 -> next cycle outValid=1, outs match, fetchStall=0.
- Stream 3 entries, decodeStall=1 on the 2nd cycle for 4 cycles -> fetchStall=1 from the following cycle until release; Decode sees 1,2,3 in order, no loss or duplicate.
- SKID state with flush=1 and decodeStall=1 -> next cycle outValid=0, outInstruction=16'h0000, fetchStall=0, state EMPTY.
- flush=1 with inValid=1 (inInstruction=16'hBEEF) in FULL -> 16'hBEEF never appears at the output; the next valid input loads normally.
- Assert rst=0 asynchronously mid-cycle while in SKID -> all outputs 0 immediately, before the next clock edge.
- FETCH_DECODE_STATS_EN defined, decodeStall=1 for 70000 valid cycles -> stallCount=16'hFFFF, with no wrap.
